// File: rtl/bmp_reader.sv
// rtl/bmp_reader.sv - BMP header parser and pixel byte streamer over a byte-wide ROM.
// Optional BMP_READER_STRIP_PAD_EN: stream width*3*height bytes, skipping row padding.
module bmp_reader #(
  parameter int ADDR_W   = 20,
  parameter int HDR_SIZE = 54
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ROM_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        ROM_odata,
  output logic              pix_valid,
  output logic [7:0]        pix_data,
  input  logic              pix_ready,
  output logic [31:0]       img_width,
  output logic [31:0]       img_height,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, HDR, PIX, DONE, ERR} state_t;
  state_t state;

  logic              hdr_iss;
  logic              rd_vld;
  logic [ADDR_W-1:0] rd_idx;
  logic [15:0]       signature;
  logic [31:0]       data_offset;
  logic [15:0]       bpp;
  logic [23:0]       width_sh;
  logic [23:0]       height_sh;
  logic [ADDR_W-1:0] rd_left;
  logic [ADDR_W-1:0] tx_left;
  logic              s_valid;
  logic [7:0]        s_data;
`ifdef BMP_READER_STRIP_PAD_EN
  logic [31:0]       row_bytes;
  logic [31:0]       col;
  logic [1:0]        pad;
`else
  logic [31:0]       file_size;
`endif

  logic        pop;
  logic        push;
  logic        hdr_last;
  logic        hdr_ok;
  logic        room;
  logic [1:0]  in_use;
  logic [31:0] hidx;
  logic [31:0] pix_count;

  assign hidx     = 32'(rd_idx);
  assign pop      = pix_valid & pix_ready;
  assign push     = rd_vld & (state == PIX);
  assign hdr_last = rd_vld & (state == HDR) & (rd_idx == ADDR_W'(HDR_SIZE - 1));
  assign hdr_ok   = (signature == 16'h4D42) && (bpp == 16'd24) &&
                    (data_offset >= 32'(HDR_SIZE));

  // A read issued now lands two edges later; reserve space assuming no further pops.
  assign in_use = 2'(pix_valid) + 2'(s_valid) + 2'(rd_vld);
  assign room   = (in_use - 2'(pop)) < 2'd2;

`ifdef BMP_READER_STRIP_PAD_EN
  assign pix_count = img_width * 32'd3 * img_height;
  assign pad       = 2'd0 - row_bytes[1:0];
`else
  assign pix_count = file_size - data_offset;
`endif

  assign ROM_valid = ((state == HDR) & hdr_iss) |
                     ((state == PIX) & (rd_left != '0) & room);
  assign busy      = (state == HDR) | (state == PIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hdr_iss     <= 1'b0;
      rd_vld      <= 1'b0;
      rd_idx      <= '0;
      rom_addr    <= '0;
      signature   <= '0;
      data_offset <= '0;
      bpp         <= '0;
      width_sh    <= '0;
      height_sh   <= '0;
      img_width   <= '0;
      img_height  <= '0;
      rd_left     <= '0;
      tx_left     <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      s_valid     <= 1'b0;
      s_data      <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef BMP_READER_STRIP_PAD_EN
      row_bytes   <= '0;
      col         <= '0;
`else
      file_size   <= '0;
`endif
    end else begin
      done   <= 1'b0;
      rd_vld <= ROM_valid;
      rd_idx <= rom_addr;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= HDR;
            hdr_iss  <= 1'b1;
            rom_addr <= '0;
            err      <= 1'b0;
          end
        end
        HDR: begin
          if (ROM_valid) begin
            if (rom_addr == ADDR_W'(HDR_SIZE - 1)) hdr_iss <= 1'b0;
            else rom_addr <= rom_addr + ADDR_W'(1);
          end
          if (rd_vld) begin
            case (hidx)
              32'd0:  signature[7:0]    <= ROM_odata;
              32'd1:  signature[15:8]   <= ROM_odata;
`ifndef BMP_READER_STRIP_PAD_EN
              32'd2:  file_size[7:0]    <= ROM_odata;
              32'd3:  file_size[15:8]   <= ROM_odata;
              32'd4:  file_size[23:16]  <= ROM_odata;
              32'd5:  file_size[31:24]  <= ROM_odata;
`endif
              32'd10: data_offset[7:0]   <= ROM_odata;
              32'd11: data_offset[15:8]  <= ROM_odata;
              32'd12: data_offset[23:16] <= ROM_odata;
              32'd13: data_offset[31:24] <= ROM_odata;
              32'd18: width_sh[7:0]      <= ROM_odata;
              32'd19: width_sh[15:8]     <= ROM_odata;
              32'd20: width_sh[23:16]    <= ROM_odata;
              32'd21: img_width          <= {ROM_odata, width_sh};
              32'd22: height_sh[7:0]     <= ROM_odata;
              32'd23: height_sh[15:8]    <= ROM_odata;
              32'd24: height_sh[23:16]   <= ROM_odata;
              32'd25: img_height         <= {ROM_odata, height_sh};
              32'd28: bpp[7:0]           <= ROM_odata;
              32'd29: bpp[15:8]          <= ROM_odata;
              default: ;
            endcase
          end
          if (hdr_last) begin
            if (!hdr_ok) begin
              state <= ERR;
              err   <= 1'b1;
            end else if (pix_count == 32'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= PIX;
              rom_addr <= data_offset[ADDR_W-1:0];
              rd_left  <= pix_count[ADDR_W-1:0];
              tx_left  <= pix_count[ADDR_W-1:0];
`ifdef BMP_READER_STRIP_PAD_EN
              row_bytes <= img_width * 32'd3;
              col       <= '0;
`endif
            end
          end
        end
        PIX: begin
          if (ROM_valid) begin
            rd_left <= rd_left - ADDR_W'(1);
`ifdef BMP_READER_STRIP_PAD_EN
            if (col == row_bytes - 32'd1) begin
              col      <= '0;
              rom_addr <= rom_addr + ADDR_W'(1) + ADDR_W'(pad);
            end else begin
              col      <= col + 32'd1;
              rom_addr <= rom_addr + ADDR_W'(1);
            end
`else
            rom_addr <= rom_addr + ADDR_W'(1);
`endif
          end
          // Two-entry FIFO: pix_data is the head, s_data the second slot.
          if (pop) begin
            if (s_valid) begin
              pix_data <= s_data;
              s_valid  <= push;
              if (push) s_data <= ROM_odata;
            end else begin
              pix_valid <= push;
              if (push) pix_data <= ROM_odata;
            end
          end else if (push) begin
            if (pix_valid) begin
              s_valid <= 1'b1;
              s_data  <= ROM_odata;
            end else begin
              pix_valid <= 1'b1;
              pix_data  <= ROM_odata;
            end
          end
          if (pop) begin
            tx_left <= tx_left - ADDR_W'(1);
            if (tx_left == ADDR_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_reader.sv
// tb/tb_bmp_reader.sv - randomized self-checking bench for bmp_reader against a byte-address reference model.
`timescale 1ns/1ps
module tb_bmp_reader;
  localparam int ADDR_W   = 20;
  localparam int HDR_SIZE = 54;
  localparam int MEM_SZ   = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              pix_ready = 1'b0;
  logic              ROM_valid;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        ROM_odata = 8'h00;
  logic              pix_valid;
  logic [7:0]        pix_data;
  logic [31:0]       img_width;
  logic [31:0]       img_height;
  logic              busy;
  logic              done;
  logic              err;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] mem [MEM_SZ];
  int         exp_addr[$];
  int         cur_w, cur_h;
  bit         exp_err;

  bmp_reader #(.ADDR_W(ADDR_W), .HDR_SIZE(HDR_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ROM_valid(ROM_valid), .rom_addr(rom_addr), .ROM_odata(ROM_odata),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .img_width(img_width), .img_height(img_height),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ROM_valid)
      ROM_odata <= (rom_addr < ADDR_W'(MEM_SZ)) ? mem[rom_addr[9:0]] : 8'h00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic put_le(input int addr, input int nbytes, input logic [31:0] v);
    for (int i = 0; i < nbytes; i++) mem[addr + i] = v[8*i +: 8];
  endtask

  // fault: 0 none, 1 bad signature, 2 bpp 32, 3 offset below header size
  task automatic build_image(input int w, input int h, input int off, input int fault);
    int row_raw, row_pad, fs;
    row_raw = w * 3;
    row_pad = (row_raw + 3) / 4 * 4;
    fs = off + row_pad * h;
    for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);
    put_le(0, 2, 32'h4D42);
    put_le(2, 4, 32'(fs));
    put_le(10, 4, (fault == 3) ? 32'd40 : 32'(off));
    put_le(18, 4, 32'(w));
    put_le(22, 4, 32'(h));
    put_le(28, 2, (fault == 2) ? 32'd32 : 32'd24);
    if (fault == 1) mem[0] = 8'h00;
    cur_w = w;
    cur_h = h;
    exp_err = (fault != 0);
    exp_addr.delete();
    if (!exp_err) begin
`ifdef BMP_READER_STRIP_PAD_EN
      for (int r = 0; r < h; r++)
        for (int c = 0; c < row_raw; c++) exp_addr.push_back(off + r * row_pad + c);
`else
      for (int a = off; a < fs; a++) exp_addr.push_back(a);
`endif
    end
  endtask

  // ready_mode: 0 always ready, 1 repeating 1,0,0,1, 2 random
  task automatic run_image(input int ready_mode, input int start_at, input int abort_at);
    int  xfers, rd_n, issued_pix, first_pix_rd, first_valid, last_xfer;
    int  ovf, stall_bad, hdr_bad, addr_bad, exp_n, cyc;
    bit  saw_valid, finished, prev_stall, pop, mid_started;
    logic [7:0] prev_data;
    bit  pat [4];
    int  pix_addrs[$];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    xfers = 0; rd_n = 0; issued_pix = 0; first_pix_rd = 0; first_valid = 0; last_xfer = 0;
    ovf = 0; stall_bad = 0; hdr_bad = 0; addr_bad = 0; exp_n = exp_addr.size();
    saw_valid = 0; finished = 0; prev_stall = 0; prev_data = 8'h00; mid_started = 0;
    for (cyc = 0; cyc < 2000 && !finished; cyc++) begin
      @(negedge clk);
      start = (cyc == 0);
      if (start_at >= 0 && xfers == start_at && !mid_started && cyc > 0) begin
        start = 1'b1;
        mid_started = 1;
      end
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = pat[cyc % 4];
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 1) check("err_cleared_busy", {err, busy}, 2'b01);
      pop = pix_valid && pix_ready;
      if (ROM_valid) begin
        rd_n++;
        if (rd_n <= HDR_SIZE) begin
          if (rom_addr != ADDR_W'(rd_n - 1)) hdr_bad++;
        end else begin
          if (issued_pix == 0) first_pix_rd = cyc;
          issued_pix++;
          pix_addrs.push_back(int'(rom_addr));
        end
      end
      if (issued_pix - xfers - int'(pop) > 2) ovf++;
      if (prev_stall && (!pix_valid || pix_data != prev_data)) stall_bad++;
      if (pix_valid && !saw_valid) begin
        saw_valid = 1;
        first_valid = cyc;
      end
      if (pop) begin
        if (abort_at > 0 && xfers == abort_at - 1) begin
          rst_n = 1'b0;
          #1;
          check("rst_mid_ctrl", {ROM_valid, pix_valid, busy, done, err, rom_addr, pix_data}, '0);
          check("rst_mid_dims", {img_width, img_height}, '0);
          start = 1'b0;
          repeat (2) @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (xfers < exp_n) check("pix_byte", pix_data, mem[exp_addr[xfers]]);
        else check("extra_byte", 64'(xfers), 64'(exp_n));
        last_xfer = cyc;
        xfers++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data = pix_data;
      if (done) begin
        check("done_count", 64'(xfers), 64'(exp_n));
        if (exp_n > 0) check("done_timing", 64'(cyc - last_xfer), 64'd1);
        finished = 1;
      end
      if (cyc >= 2 && err && !busy) finished = 1;
    end
    start = 1'b0;
    if (!finished) check("timeout", 64'd0, 64'd1);
    if (exp_err) begin
      check("err_flag", err, 1'b1);
      check("no_pix_on_err", 64'(saw_valid), 64'd0);
    end else begin
      check("err_flag", err, 1'b0);
      check("img_width", img_width, 32'(cur_w));
      check("img_height", img_height, 32'(cur_h));
      check("hdr_addrs", 64'(hdr_bad), 64'd0);
      if (pix_addrs.size() != exp_n) addr_bad++;
      else for (int i = 0; i < exp_n; i++) if (pix_addrs[i] != exp_addr[i]) addr_bad++;
      check("pix_addrs", 64'(addr_bad), 64'd0);
      check("fifo_overflow", 64'(ovf), 64'd0);
      check("stall_hold", 64'(stall_bad), 64'd0);
      if (exp_n == 0) check("no_pix_zero", 64'(saw_valid), 64'd0);
      else if (ready_mode == 0) begin
        check("first_valid_lat", 64'(first_valid - first_pix_rd), 64'd2);
        check("back_to_back", 64'(last_xfer - first_valid), 64'(exp_n - 1));
      end
      @(negedge clk);
      #1;
      check("done_pulse_width", done, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", {ROM_valid, pix_valid, busy, done, err, rom_addr, pix_data}, '0);
    check("reset_dims", {img_width, img_height}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    build_image(2, 2, 54, 0);
    run_image(0, -1, 0);

    build_image(3, 2, 54, 1);
    run_image(0, -1, 0);
    build_image(3, 3, 56, 0);
    run_image(1, -1, 0);

    build_image(2, 2, 54, 2);
    run_image(2, -1, 0);
    build_image(2, 2, 54, 3);
    run_image(0, -1, 0);

    build_image(0, 2, 54, 0);
    run_image(0, -1, 0);

    build_image(4, 2, 55, 0);
    run_image(0, 3, 0);

    build_image(3, 3, 54, 0);
    run_image(0, -1, 5);
    run_image(0, -1, 0);

    for (int k = 0; k < 6; k++) begin
      build_image($urandom_range(1, 5), $urandom_range(1, 4), 54 + $urandom_range(0, 6), 0);
      run_image($urandom_range(0, 2), -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bmp_reader.md
BMP_READER -- requirements
Module: bmp_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, giving the width of the ROM byte address.
REQ-002 SHALL have parameter HDR_SIZE, default 54, giving the number of BMP header bytes fetched before pixel data.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin reading an image from address 0.
REQ-006 SHALL have port ROM_valid  output  1  ROM read strobe; one byte is requested per cycle it is high.
REQ-007 SHALL have port rom_addr  output  ADDR_W  ROM byte address, meaningful while ROM_valid is high.
REQ-008 SHALL have port ROM_odata  input  8  ROM read data, valid on the cycle after the ROM_valid cycle that requested it.
REQ-009 SHALL have port pix_valid  output  1  pix_data holds a pixel-stream byte.
REQ-010 SHALL have port pix_data  output  8  pixel-stream byte, in file order.
REQ-011 SHALL have port pix_ready  input  1  downstream accept; a byte transfers when pix_valid and pix_ready are both high.
REQ-012 SHALL have port img_width  output  32  width from header bytes 18-21, little-endian.
REQ-013 SHALL have port img_height  output  32  height from header bytes 22-25, little-endian.
REQ-014 SHALL have port busy  output  1  high in every state other than IDLE, DONE and ERR.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the last pixel byte transfers.
REQ-016 SHALL have port err  output  1  sticky header-error flag.

Function
REQ-017 SHALL implement states IDLE, HDR, PIX, DONE and ERR; start in IDLE, DONE or ERR moves to HDR, clears err and resets rom_addr to 0; start while busy SHALL be ignored.
REQ-018 In HDR the block SHALL issue reads at addresses 0..HDR_SIZE-1 on consecutive cycles and capture:
- signature: bytes 0-1
- file_size: bytes 2-5
- data_offset: bytes 10-13
- width: bytes 18-21
- height: bytes 22-25
- bpp: bytes 28-29
All multi-byte fields are little-endian.
REQ-019 After the last header byte returns, the block SHALL enter ERR if signature != 0x42,0x4D, or bpp != 24, or data_offset < HDR_SIZE; otherwise it SHALL enter PIX, with rom_addr = data_offset.
REQ-020 In PIX, read data SHALL enter a 2-entry output FIFO, with pix_valid/pix_data driven from the FIFO head register.
REQ-021 A read SHALL be issued only when (FIFO occupancy + outstanding reads - pop this cycle) < 2, so the FIFO never overflows.
REQ-022 With pix_ready held high, PIX SHALL sustain one byte per cycle, and the first pix_valid SHALL rise 2 cycles after the first PIX read.
REQ-023 pix_data SHALL hold stable while pix_valid is high and pix_ready is low.
REQ-024 When the final byte transfers, the block SHALL pulse done and enter DONE; a computed pixel byte count of 0 SHALL go from HDR directly to DONE, with a done pulse and no pix_valid.
REQ-025 img_width and img_height SHALL update when their last byte is captured and hold until the next start.
REQ-026 The byte counter and rom_addr SHALL be ADDR_W bits wide, and all byte-count arithmetic SHALL use 32 bits.

Reset
REQ-027 rst_n low SHALL immediately force IDLE and clear ROM_valid, rom_addr, pix_valid, pix_data, img_width, img_height, busy, done, err and the FIFO, including mid-HDR or mid-PIX; read data returning after reset SHALL be discarded.

Configuration
REQ-028 Macro BMP_READER_STRIP_PAD_EN SHALL select the pixel stream content:
- Defined: pixel byte count is width*3*height, and the (4 - (width*3 mod 4)) mod 4 padding bytes at the end of each row SHALL be skipped (addresses advanced, not read).
- Undefined: pixel byte count is file_size - data_offset, and bytes are streamed raw, including padding.

Verification
REQ-029 2x2 24bpp image (file_size 70, offset 54), pix_ready always 1, macro undefined -> 16 bytes streamed back-to-back, img_width=2, img_height=2, done pulse after byte 16.
REQ-030 Same image, macro defined -> 12 bytes streamed; addresses 60-61 and 68-69 never requested.
REQ-031 Byte 0 = 0x00 -> err=1, state ERR, no pix_valid; a following start on a valid image clears err.
REQ-032 pix_ready toggling 1,0,0,1 -> no lost or duplicated bytes, pix_data stable while stalled, ROM_valid never high with FIFO full.
REQ-033 rst_n asserted at the 5th PIX byte -> all outputs zero in the same cycle; a new start after release streams from byte 0.
REQ-034 start pulsed during PIX -> ignored, stream completes normally.
